// File: rtl/spi_master_arbiter_pkg.sv
// Shared definitions for the two-requester SPI master: state encoding,
// requester ids and the round-robin winner selection.
package spi_master_arbiter_pkg;

   localparam int W_SPI_DATA = 32;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LDR = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   // A lone request wins; on a tie the requester that did not win last time wins.
   function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
      logic win;
      if (r0 && r1) begin
         win = ~last;
      end else if (r1) begin
         win = REQ_LDR;
      end else begin
         win = REQ_CPU;
      end
      return win;
   endfunction

endpackage

// File: rtl/spi_master_arbiter_shifter.sv
// Transmit/receive shift registers plus the falling-edge bit counter
// for one MSB-first SPI word.
module spi_shifter
   import spi_master_arbiter_pkg::*;
#(
   parameter int W_DATA = W_SPI_DATA
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              rise,
   input  logic              fall,
   input  logic [W_DATA-1:0] load_data,
   input  logic              miso,
   output logic              mosi,
   output logic [W_DATA-1:0] rx_data,
   output logic              last_bit
);

   localparam int W_CNT = (W_DATA > 1) ? $clog2(W_DATA) : 1;
   localparam logic [W_CNT-1:0] CNT_ONE  = W_CNT'(1);
   localparam logic [W_CNT-1:0] CNT_ZERO = W_CNT'(0);
   localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(W_DATA - 1);

   logic [W_DATA-1:0] tx_r;
   logic [W_DATA-1:0] rx_r;
   logic [W_CNT-1:0]  bit_cnt_r;

   // Shift engine: zeros refill the transmit side so mosi idles low after a word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_r      <= {W_DATA{1'b0}};
         rx_r      <= {W_DATA{1'b0}};
         bit_cnt_r <= CNT_ZERO;
      end else if (load) begin
         tx_r      <= load_data;
         rx_r      <= {W_DATA{1'b0}};
         bit_cnt_r <= CNT_ZERO;
      end else begin
         if (rise) begin
            rx_r <= {rx_r[W_DATA-2:0], miso};
         end
         if (fall) begin
            tx_r      <= {tx_r[W_DATA-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
         end
      end
   end

   assign mosi     = tx_r[W_DATA-1];
   assign rx_data  = rx_r;
   assign last_bit = (bit_cnt_r == CNT_LAST);

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one mode-0 SPI shift engine between the CPU
// register path (requester 0) and the boot loader (requester 1).
module spi_master_arbiter
   import spi_master_arbiter_pkg::*;
#(
   parameter int W_DATA  = W_SPI_DATA,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [W_DATA-1:0] wdata0,
   output logic              done0,
   output logic [W_DATA-1:0] rdata0,
   input  logic              req1,
   input  logic [W_DATA-1:0] wdata1,
   output logic              done1,
   output logic [W_DATA-1:0] rdata1,
   output logic              busy,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [1:0]        cs_n
);

   localparam int W_DIV = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W_DIV-1:0] DIV_MAX  = W_DIV'(CLK_DIV - 1);
   localparam logic [W_DIV-1:0] DIV_ONE  = W_DIV'(1);
   localparam logic [W_DIV-1:0] DIV_ZERO = W_DIV'(0);

   state_e            state_r, next_s;
   logic              grant_r, last_grant_r, win_s, gid_s, grant_go_s;
   logic              tick_s, rise_s, fall_s, last_bit_s;
   logic [W_DIV-1:0]  div_r;
   logic [W_DATA-1:0] load_data_s, rx_data_s, rdata0_r, rdata1_r;
   logic [1:0]        cs_n_s, cs_n_r;
   logic              sclk_s, sclk_r, done0_s, done1_s, done0_r, done1_r, busy_r;

   assign win_s       = pick_winner(req0, req1, last_grant_r);
   assign grant_go_s  = (state_r == S_IDLE) && (req0 || req1);
   assign load_data_s = (win_s == REQ_LDR) ? wdata1 : wdata0;
   assign tick_s      = (div_r == DIV_ZERO);
   assign rise_s      = (state_r == S_SHIFT) && tick_s && !sclk_r;
   assign fall_s      = (state_r == S_SHIFT) && tick_s && sclk_r;

   spi_shifter #(.W_DATA(W_DATA)) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (grant_go_s),
      .rise      (rise_s),
      .fall      (fall_s),
      .load_data (load_data_s),
      .miso      (miso),
      .mosi      (mosi),
      .rx_data   (rx_data_s),
      .last_bit  (last_bit_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_IDLE:  next_s = (req0 || req1) ? S_SETUP : S_IDLE;
         S_SETUP: next_s = tick_s ? S_SHIFT : S_SETUP;
         S_SHIFT: next_s = (fall_s && last_bit_s) ? S_HOLD : S_SHIFT;
         S_HOLD:  next_s = tick_s ? S_DONE : S_HOLD;
         S_DONE:  next_s = S_IDLE;
         default: next_s = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every pin comes straight from a flop
   always_comb begin
      gid_s   = (state_r == S_IDLE) ? win_s : grant_r;
      cs_n_s  = 2'b11;
      sclk_s  = 1'b0;
      case (next_s)
         S_SETUP, S_HOLD: cs_n_s[gid_s] = 1'b0;
         S_SHIFT: begin
            cs_n_s[gid_s] = 1'b0;
            if (state_r == S_SHIFT) begin
               sclk_s = tick_s ? ~sclk_r : sclk_r;
            end else begin
               sclk_s = 1'b0;
            end
         end
         default: cs_n_s = 2'b11;
      endcase
      if (state_r == S_DONE) begin
         done0_s = (grant_r == REQ_CPU);
         done1_s = (grant_r == REQ_LDR);
      end else begin
         done0_s = 1'b0;
         done1_s = 1'b0;
      end
   end

   // Grant bookkeeping and the SCLK half-period divider
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_r      <= REQ_CPU;
         last_grant_r <= REQ_LDR;
         div_r        <= DIV_ZERO;
      end else begin
         if (grant_go_s) begin
            grant_r      <= win_s;
            last_grant_r <= win_s;
         end
         if (grant_go_s || tick_s) begin
            div_r <= DIV_MAX;
         end else begin
            div_r <= div_r - DIV_ONE;
         end
      end
   end

   // Registered outputs; a reset mid-word discards the partial result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_n_r   <= 2'b11;
         sclk_r   <= 1'b0;
         done0_r  <= 1'b0;
         done1_r  <= 1'b0;
         busy_r   <= 1'b0;
         rdata0_r <= {W_DATA{1'b0}};
         rdata1_r <= {W_DATA{1'b0}};
      end else begin
         cs_n_r  <= cs_n_s;
         sclk_r  <= sclk_s;
         done0_r <= done0_s;
         done1_r <= done1_s;
         busy_r  <= (next_s != S_IDLE);
         if (done0_s) begin
            rdata0_r <= rx_data_s;
         end
         if (done1_s) begin
            rdata1_r <= rx_data_s;
         end
      end
   end

   assign cs_n   = cs_n_r;
   assign sclk   = sclk_r;
   assign done0  = done0_r;
   assign done1  = done1_r;
   assign busy   = busy_r;
   assign rdata0 = rdata0_r;
   assign rdata1 = rdata1_r;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboarded bench: stimulus pushes expected completions, a negedge monitor
// checks each done pulse (id, data, latency, SCLK/CS waveform) against them.
module tb_spi_master_arbiter;

   localparam int W    = 8;
   localparam int D    = 2;
   localparam int LAT  = (2*W + 2)*D + 1;
   localparam int W2   = 32;
   localparam int D2   = 1;
   localparam int LAT2 = (2*W2 + 2)*D2 + 1;

   typedef struct {
      logic         id;
      logic [W-1:0] rdata;
      logic [W-1:0] wdata;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0]  wdata0 = '0, wdata1 = '0;
   logic          done0, done1, busy, sclk, mosi, miso;
   logic [W-1:0]  rdata0, rdata1;
   logic [1:0]    cs_n;
   int            miso_mode = 0;

   logic          req0_b = 1'b0;
   logic [W2-1:0] wdata0_b = '0;
   logic          done0_b, done1_b, busy_b, sclk_b, mosi_b;
   logic [W2-1:0] rdata0_b, rdata1_b;
   logic [1:0]    cs_n_b;

   assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

   spi_master_arbiter #(.W_DATA(W), .CLK_DIV(D)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
      .req1(req1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
      .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
   );

   spi_master_arbiter #(.W_DATA(W2), .CLK_DIV(D2)) u_dut32 (
      .clk(clk), .rst(rst),
      .req0(req0_b), .wdata0(wdata0_b), .done0(done0_b), .rdata0(rdata0_b),
      .req1(1'b0), .wdata1({W2{1'b0}}), .done1(done1_b), .rdata1(rdata1_b),
      .busy(busy_b), .sclk(sclk_b), .mosi(mosi_b), .miso(mosi_b), .cs_n(cs_n_b)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   exp_t         exp_q[$];
   logic         model_last = 1'b1;
   logic [W-1:0] model_rd [2] = '{default: '0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rx_model(input logic [W-1:0] data, input int mode);
      if (mode == 0) return data;
      else if (mode == 1) return {W{1'b1}};
      else return {W{1'b0}};
   endfunction

   // Monitor state
   logic [1:0]   prev_cs = 2'b11;
   logic         prev_sclk = 1'b0;
   logic         cur_id = 1'b0;
   logic         other_ok = 1'b1;
   int           grant_cyc = 0, cs_low_cnt = 0, rise_cnt = 0, idle_run = 100;
   logic [W-1:0] tx_seen = '0;
   exp_t         e;

   always @(negedge clk) begin
      if (!rst) begin
         prev_cs   = 2'b11;
         prev_sclk = 1'b0;
         idle_run  = 100;
      end else begin
         if (cs_n != 2'b11 && prev_cs == 2'b11) begin
            check("idle_gap", idle_run >= 2, 1'b1);
            cur_id     = cs_n[0] ? 1'b1 : 1'b0;
            grant_cyc  = cyc;
            cs_low_cnt = 0;
            rise_cnt   = 0;
            tx_seen    = '0;
            other_ok   = 1'b1;
         end
         if (cs_n == 2'b11) idle_run++;
         else idle_run = 0;
         if (cs_n == 2'b00) other_ok = 1'b0;
         if (cs_n[cur_id] == 1'b0) cs_low_cnt++;
         if (sclk && !prev_sclk) begin
            rise_cnt++;
            tx_seen = {tx_seen[W-2:0], mosi};
         end
         if (done0 || done1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: done0=%0b done1=%0b, expected none", done0, done1);
            end else begin
               e = exp_q.pop_front();
               check("done_onehot", done0 && done1, 1'b0);
               check("done_id", done1, e.id);
               check("grant_id", cur_id, e.id);
               check("rdata", e.id ? rdata1 : rdata0, e.rdata);
               check("other_rdata", e.id ? rdata0 : rdata1, model_rd[!e.id]);
               check("latency", cyc - grant_cyc, LAT);
               check("cs_low_cycles", cs_low_cnt, LAT - 1);
               check("sclk_rises", rise_cnt, W);
               check("mosi_bits", tx_seen, e.wdata);
               check("other_cs_high", other_ok, 1'b1);
               model_rd[e.id] = e.rdata;
            end
         end
         prev_cs   = cs_n;
         prev_sclk = sclk;
      end
   end

   task automatic do_xfer(input logic id, input logic [W-1:0] data, input int mode, input int drop_after);
      int t;
      logic seen;
      @(negedge clk);
      miso_mode = mode;
      if (id) begin wdata1 = data; req1 = 1'b1; end
      else begin wdata0 = data; req0 = 1'b1; end
      exp_q.push_back('{id, rx_model(data, mode), data});
      model_last = id;
      t = 0;
      seen = 1'b0;
      while (!seen && t < 500) begin
         @(negedge clk);
         t++;
         if (t == 2) check("busy_in_xfer", busy, 1'b1);
         if (t == 3) begin
            if (id) wdata1 = W'($urandom);
            else wdata0 = W'($urandom);
         end
         if (t == drop_after) begin
            if (id) req1 = 1'b0;
            else req0 = 1'b0;
         end
         if (id ? done1 : done0) seen = 1'b1;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check("xfer_completed", seen, 1'b1);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_both(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
      int t, cnt;
      logic g;
      @(negedge clk);
      miso_mode = 0;
      wdata0 = a;
      wdata1 = b;
      req0 = 1'b1;
      req1 = 1'b1;
      g = model_last;
      for (int k = 0; k < n; k++) begin
         g = ~g;
         exp_q.push_back('{g, g ? b : a, g ? b : a});
      end
      model_last = g;
      t = 0;
      cnt = 0;
      while (cnt < n && t < 200*n) begin
         @(negedge clk);
         t++;
         if (done0 || done1) cnt++;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check("rr_all_done", cnt, n);
      repeat (3) @(negedge clk);
   endtask

   task automatic xfer32(input logic [W2-1:0] data);
      int t, g;
      @(negedge clk);
      wdata0_b = data;
      req0_b = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (cs_n_b[0] != 1'b0 && t < 20);
      g = cyc;
      check("cs32_other_high", cs_n_b[1], 1'b1);
      t = 0;
      while (!done0_b && t < 200) begin @(negedge clk); t++; end
      req0_b = 1'b0;
      check("latency32", cyc - g, LAT2);
      check("rdata32", rdata0_b, data);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n, 2'b11);
      check("rst_sclk", sclk, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", {done0, done1}, 2'b00);
      check("rst_rdata0", rdata0, '0);
      check("rst_rdata1", rdata1, '0);
      check("rst_cs_n32", cs_n_b, 2'b11);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      do_xfer(1'b0, 8'hA5, 0, 0);
      do_xfer(1'b1, 8'h00, 1, 0);
      do_both(W'($urandom), W'($urandom), 4);
      do_xfer(1'b0, 8'h3C, 0, 10);
      for (int i = 0; i < 16; i++) begin
         do_xfer(1'($urandom_range(0, 1)), W'($urandom), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 30)) : 0);
      end
      do_both(W'($urandom), W'($urandom), 3);

      // Reset in the middle of a CPU transfer
      @(negedge clk);
      miso_mode = 0;
      wdata0 = 8'h5A;
      req0 = 1'b1;
      repeat (20) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("mid_rst_cs_n", cs_n, 2'b11);
      check("mid_rst_sclk", sclk, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      req0 = 1'b0;
      exp_q.delete();
      model_rd[0] = '0;
      model_rd[1] = '0;
      model_last = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_rdata0", rdata0, '0);
      check("mid_rst_rdata1", rdata1, '0);
      rst = 1'b1;
      repeat (50) @(negedge clk);
      do_both(W'($urandom), W'($urandom), 2);

      xfer32(32'hDEADBEEF);
      xfer32(W2'($urandom));

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
